// File: rtl/nand_init_sequencer.sv
// Purpose : autonomous NAND bring-up; on start it drives nand_master through
//           reset, chip enable, NAND reset, read ID, ID byte fetches, status.
// Latency : per step 1 (issue) + SETTLE_CYC + busy wait (>=1) + 1 (capture).
// Backpressure: waits on m_busy per step; a step stuck busy for TIMEOUT_CYC
//           WAIT cycles aborts with error/err_step. start ignored unless idle.
// Ports   : clk/nreset, start/ce_sel (request), m_* (nand_master command
//           interface), seq_busy/done/error/err_step/id_bytes/status (results).
module nand_init_sequencer #(
   parameter int unsigned ID_BYTES       = 5,
   parameter int unsigned SETTLE_CYC     = 2,
   parameter int unsigned TIMEOUT_CYC    = 65535,
   parameter logic [5:0]  CMD_RESET      = 6'h01,
   parameter logic [5:0]  CMD_CHIP_EN    = 6'h0E,
   parameter logic [5:0]  CMD_NAND_RESET = 6'h04,
   parameter logic [5:0]  CMD_READ_ID    = 6'h06,
   parameter logic [5:0]  CMD_GET_ID     = 6'h13,
   parameter logic [5:0]  CMD_GET_STATUS = 6'h0D
) (
   input  logic                    clk,
   input  logic                    nreset,
   input  logic                    start,
   input  logic [7:0]              ce_sel,
   output logic [5:0]              m_cmd_in,
   output logic                    m_activate,
   output logic [7:0]              m_data_in,
   input  logic [7:0]              m_data_out,
   input  logic                    m_busy,
   output logic                    seq_busy,
   output logic                    done,
   output logic                    error,
   output logic [3:0]              err_step,
   output logic [8*ID_BYTES-1:0]   id_bytes,
   output logic [7:0]              status
);

   localparam logic [3:0]  LAST_STEP   = 4'(4 + ID_BYTES);
   localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_CYC - 1);
   localparam logic [15:0] TMO_LAST    = 16'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_SETTLE, S_WAIT, S_CAPTURE, S_DONE, S_ERROR
   } state_t;

   state_t                 state_q, state_d;
   logic [3:0]             step_q, step_d;
   logic [3:0]             settle_q, settle_d;
   logic [15:0]            tmo_q, tmo_d;
   logic [7:0]             ce_q, ce_d;
   logic [5:0]             cmd_q, cmd_d;
   logic [7:0]             dat_q, dat_d;
   logic                   done_q, done_d;
   logic                   error_q, error_d;
   logic [3:0]             err_step_q, err_step_d;
   logic [8*ID_BYTES-1:0]  id_q, id_d;
   logic [7:0]             status_q, status_d;

   function automatic logic [5:0] cmd_for(input logic [3:0] s);
      logic [5:0] c;
      case (s)
         4'd0:    c = CMD_RESET;
         4'd1:    c = CMD_CHIP_EN;
         4'd2:    c = CMD_NAND_RESET;
         4'd3:    c = CMD_READ_ID;
         default: c = (s == LAST_STEP) ? CMD_GET_STATUS : CMD_GET_ID;
      endcase
      return c;
   endfunction

   always_comb begin
      state_d    = state_q;
      step_d     = step_q;
      settle_d   = settle_q;
      tmo_d      = tmo_q;
      ce_d       = ce_q;
      cmd_d      = cmd_q;
      dat_d      = dat_q;
      done_d     = done_q;
      error_d    = error_q;
      err_step_d = err_step_q;
      id_d       = id_q;
      status_d   = status_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               ce_d     = ce_sel;
               step_d   = 4'd0;
               settle_d = 4'd0;
               tmo_d    = 16'd0;
               done_d   = 1'b0;
               error_d  = 1'b0;
               id_d     = '0;
               cmd_d    = cmd_for(4'd0);
               dat_d    = 8'h00;
               state_d  = S_ISSUE;
            end
         end
         S_ISSUE: begin
            settle_d = 4'd0;
            state_d  = S_SETTLE;
         end
         S_SETTLE: begin
            if (settle_q == SETTLE_LAST) begin
               tmo_d   = 16'd0;
               state_d = S_WAIT;
            end else begin
               settle_d = settle_q + 4'd1;
            end
         end
         S_WAIT: begin
            if (!m_busy) begin
               state_d = S_CAPTURE;
            end else if (tmo_q == TMO_LAST) begin
               error_d    = 1'b1;
               err_step_d = step_q;
               cmd_d      = 6'h00;
               dat_d      = 8'h00;
               state_d    = S_ERROR;
            end else begin
               tmo_d = tmo_q + 16'd1;
            end
         end
         S_CAPTURE: begin
            for (int k = 0; k < ID_BYTES; k++) begin
               if (step_q == 4'(4 + k)) id_d[8*k +: 8] = m_data_out;
            end
            if (step_q == LAST_STEP) begin
               status_d = m_data_out;
               done_d   = 1'b1;
               state_d  = S_DONE;
            end else begin
               step_d  = step_q + 4'd1;
               tmo_d   = 16'd0;
               // Next command is loaded here so it is already stable when
               // the one-cycle activate strobe is raised in ISSUE.
               cmd_d   = cmd_for(step_q + 4'd1);
               dat_d   = (step_q == 4'd0) ? ce_q : 8'h00;
               state_d = S_ISSUE;
            end
         end
         // DONE/ERROR last one cycle so a start coinciding with completion
         // is not taken as a new request.
         S_DONE:  state_d = S_IDLE;
         S_ERROR: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q    <= S_IDLE;
         step_q     <= 4'd0;
         settle_q   <= 4'd0;
         tmo_q      <= 16'd0;
         ce_q       <= 8'h00;
         cmd_q      <= 6'h00;
         dat_q      <= 8'h00;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         err_step_q <= 4'd0;
         id_q       <= '0;
         status_q   <= 8'h00;
      end else begin
         state_q    <= state_d;
         step_q     <= step_d;
         settle_q   <= settle_d;
         tmo_q      <= tmo_d;
         ce_q       <= ce_d;
         cmd_q      <= cmd_d;
         dat_q      <= dat_d;
         done_q     <= done_d;
         error_q    <= error_d;
         err_step_q <= err_step_d;
         id_q       <= id_d;
         status_q   <= status_d;
      end
   end

   // Decoded from the state register so reset removes them immediately.
   assign m_activate = (state_q == S_ISSUE);
   assign seq_busy   = (state_q == S_ISSUE) || (state_q == S_SETTLE) ||
                       (state_q == S_WAIT)  || (state_q == S_CAPTURE);

   assign m_cmd_in  = cmd_q;
   assign m_data_in = dat_q;
   assign done      = done_q;
   assign error     = error_q;
   assign err_step  = err_step_q;
   assign id_bytes  = id_q;
   assign status    = status_q;

endmodule

// File: tb/tb_nand_init_sequencer.sv
// Bench for nand_init_sequencer: a nand_master stub answers commands, an
// expected-command queue is filled per run and drained by the monitor on
// every activate strobe; run results are compared against a plain model.
module tb_nand_init_sequencer;
   localparam int IDB   = 5;
   localparam int SET   = 2;
   localparam int TMO   = 300;
   localparam int NSTEP = IDB + 5;

   logic                 clk = 1'b0;
   logic                 nreset = 1'b0;
   logic                 start = 1'b0;
   logic [7:0]           ce_sel = 8'h00;
   logic [5:0]           m_cmd_in;
   logic                 m_activate;
   logic [7:0]           m_data_in;
   logic [7:0]           m_data_out = 8'h00;
   logic                 m_busy = 1'b0;
   logic                 seq_busy, done, error;
   logic [3:0]           err_step;
   logic [8*IDB-1:0]     id_bytes;
   logic [7:0]           status;

   nand_init_sequencer #(.ID_BYTES(IDB), .SETTLE_CYC(SET), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .nreset(nreset), .start(start), .ce_sel(ce_sel),
      .m_cmd_in(m_cmd_in), .m_activate(m_activate), .m_data_in(m_data_in),
      .m_data_out(m_data_out), .m_busy(m_busy), .seq_busy(seq_busy),
      .done(done), .error(error), .err_step(err_step), .id_bytes(id_bytes),
      .status(status)
   );

   always #5 clk = ~clk;

   typedef struct packed { logic [5:0] cmd; logic [7:0] dat; } act_t;

   int         checks = 0;
   int         failures = 0;
   act_t       exp_q[$];
   int         act_cnt = 0;
   int         base = 0;
   int         cyc = 0;
   int         busy_plan[NSTEP];
   int         act_time[NSTEP];
   logic [7:0] id_tab[IDB];
   logic [7:0] stat_v;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Command table straight from the step list.
   function automatic act_t step_act(input int s, input logic [7:0] ce);
      act_t a;
      a.dat = (s == 1) ? ce : 8'h00;
      if (s == 0)            a.cmd = 6'h01;
      else if (s == 1)       a.cmd = 6'h0E;
      else if (s == 2)       a.cmd = 6'h04;
      else if (s == 3)       a.cmd = 6'h06;
      else if (s < 4 + IDB)  a.cmd = 6'h13;
      else                   a.cmd = 6'h0D;
      return a;
   endfunction

   // nand_master stub plus monitor.
   initial begin
      int   busy_left;
      int   s;
      logic prev_act;
      act_t e;
      act_t cur;
      busy_left = 0;
      prev_act  = 1'b0;
      cur       = '0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (m_activate === 1'b1) begin
            s = act_cnt - base;
            act_cnt++;
            if (s >= 0 && s < NSTEP) begin
               act_time[s] = cyc;
               busy_left   = busy_plan[s];
               if (s >= 4 && s < 4 + IDB) m_data_out = id_tab[s-4];
               else if (s == 4 + IDB)     m_data_out = stat_v;
               else                       m_data_out = 8'($urandom);
            end
            chk("activate_width", 64'(prev_act), 64'(0));
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_activate actual=cmd %0h required=no activate", m_cmd_in);
            end else begin
               e = exp_q.pop_front();
               chk("cmd_order", 64'(m_cmd_in), 64'(e.cmd));
               chk("cmd_data_in", 64'(m_data_in), 64'(e.dat));
            end
            cur = {m_cmd_in, m_data_in};
         end else if (seq_busy === 1'b1) begin
            chk("cmd_stable", 64'({m_cmd_in, m_data_in}), 64'(cur));
         end
         prev_act = m_activate;
         m_busy = (busy_left > 0);
         if (busy_left > 0) busy_left--;
      end
   end

   // Fill tables for one run; stuck >= 0 makes that step busy far past timeout.
   task automatic prep(input logic [7:0] ce, input int stuck, input bit rnd_busy);
      int last;
      for (int k = 0; k < IDB; k++) id_tab[k] = 8'($urandom);
      stat_v = 8'($urandom);
      last = (stuck >= 0) ? stuck : NSTEP - 1;
      for (int s = 0; s < NSTEP; s++) begin
         busy_plan[s] = 0;
         if (rnd_busy && $urandom_range(0, 2) == 0) busy_plan[s] = $urandom_range(1, 25);
         act_time[s] = 0;
      end
      if (stuck >= 0) busy_plan[stuck] = 1000;
      for (int s = 0; s <= last; s++) exp_q.push_back(step_act(s, ce));
      ce_sel = ce;
   endtask

   task automatic pulse_start();
      @(posedge clk);
      #2;
      base  = act_cnt;
      start = 1'b1;
      @(posedge clk);
      #2;
      start = 1'b0;
      chk("start_seq_busy", 64'(seq_busy), 64'(1));
      chk("start_clears_done", 64'(done), 64'(0));
      chk("start_clears_error", 64'(error), 64'(0));
      chk("start_clears_id", 64'(id_bytes), 64'(0));
   endtask

   task automatic wait_end(input bit extra, output int end_cyc);
      bit fin;
      fin = 1'b0;
      end_cyc = 0;
      for (int i = 0; i < 4000 && !fin; i++) begin
         @(posedge clk);
         #2;
         start = 1'b0;
         if (extra && i == 3) ce_sel = 8'h05;
         if (extra && (i == 7 || i == 23)) start = 1'b1;
         if (done === 1'b1 || error === 1'b1) begin
            fin = 1'b1;
            end_cyc = cyc;
         end
      end
      start = 1'b0;
      if (!fin) begin
         checks++;
         failures++;
         $display("FAIL run_end_timeout actual=no done/error required=done or error");
      end
   endtask

   task automatic check_ok();
      logic [8*IDB-1:0] exp_id;
      exp_id = '0;
      for (int k = 0; k < IDB; k++) exp_id[8*k +: 8] = id_tab[k];
      chk("done", 64'(done), 64'(1));
      chk("error", 64'(error), 64'(0));
      chk("seq_busy_end", 64'(seq_busy), 64'(0));
      chk("id_bytes", 64'(id_bytes), 64'(exp_id));
      chk("status", 64'(status), 64'(stat_v));
      chk("trace_complete", 64'(exp_q.size()), 64'(0));
   endtask

   initial begin
      int t;
      logic [8*IDB-1:0] held_id;

      // Reset state
      repeat (3) @(posedge clk);
      #2;
      chk("rst_activate", 64'(m_activate), 64'(0));
      chk("rst_cmd", 64'(m_cmd_in), 64'(0));
      chk("rst_data_in", 64'(m_data_in), 64'(0));
      chk("rst_flags", 64'({seq_busy, done, error, err_step}), 64'(0));
      chk("rst_results", 64'({id_bytes, status}), 64'(0));
      nreset = 1'b1;
      repeat (2) @(posedge clk);

      // Run A: known ID, no busy, exact length
      prep(8'h00, -1, 1'b0);
      id_tab[0] = 8'hEC; id_tab[1] = 8'h76; id_tab[2] = 8'h5A;
      id_tab[3] = 8'h3F; id_tab[4] = 8'h74; stat_v = 8'hC0;
      pulse_start();
      wait_end(1'b0, t);
      check_ok();
      chk("known_id", 64'(id_bytes), 64'h743F5A76EC);
      chk("seq_length", 64'(t - act_time[0]), 64'(NSTEP * (3 + SET)));

      // Run B: NAND reset held busy 200 cycles
      prep(8'($urandom), -1, 1'b1);
      busy_plan[2] = 200;
      pulse_start();
      wait_end(1'b0, t);
      check_ok();
      chk("busy_gap_ge_200", 64'((act_time[3] - act_time[2]) >= 200), 64'(1));

      // Run C: ce_sel latched, extra starts ignored
      prep(8'h02, -1, 1'b0);
      pulse_start();
      wait_end(1'b1, t);
      check_ok();
      chk("extra_start_length", 64'(t - act_time[0]), 64'(NSTEP * (3 + SET)));

      // Random runs
      for (int r = 0; r < 3; r++) begin
         prep(8'($urandom), -1, 1'b1);
         pulse_start();
         wait_end(1'b0, t);
         check_ok();
      end

      // Timeout on step 3
      prep(8'($urandom), 3, 1'b0);
      pulse_start();
      wait_end(1'b0, t);
      chk("tmo_error", 64'(error), 64'(1));
      chk("tmo_done", 64'(done), 64'(0));
      chk("tmo_err_step", 64'(err_step), 64'(3));
      chk("tmo_seq_busy", 64'(seq_busy), 64'(0));
      chk("tmo_latency", 64'(t - act_time[3]), 64'(1 + SET + TMO));
      chk("tmo_cmd_cleared", 64'({m_cmd_in, m_data_in}), 64'(0));
      chk("tmo_id_partial", 64'(id_bytes), 64'(0));
      repeat (800) @(posedge clk);
      #2;
      chk("tmo_no_more_acts", 64'(act_cnt - base), 64'(4));
      chk("tmo_error_sticky", 64'(error), 64'(1));

      // Reset during step 5 WAIT
      prep(8'($urandom), -1, 1'b0);
      busy_plan[5] = 40;
      pulse_start();
      for (int i = 0; i < 500 && (act_cnt - base) < 6; i++) @(posedge clk);
      repeat (SET + 3) @(posedge clk);
      #2;
      held_id = id_bytes;
      chk("mid_wait_busy", 64'(seq_busy), 64'(1));
      chk("mid_id_nonempty", 64'(held_id[7:0]), 64'(id_tab[0]));
      #1;
      nreset = 1'b0;
      #1;
      chk("arst_activate", 64'(m_activate), 64'(0));
      chk("arst_cmd", 64'({m_cmd_in, m_data_in}), 64'(0));
      chk("arst_flags", 64'({seq_busy, done, error, err_step}), 64'(0));
      chk("arst_results", 64'({id_bytes, status}), 64'(0));
      repeat (60) @(posedge clk);
      exp_q.delete();
      #2;
      nreset = 1'b1;
      repeat (2) @(posedge clk);
      prep(8'($urandom), -1, 1'b1);
      pulse_start();
      wait_end(1'b0, t);
      check_ok();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
